// File: rtl/mips_harvard_bus_bridge_pkg.sv
// Shared types and constants for the Harvard-to-single-bus bridge.
// The bridge RTL and the testbench both import this package.
package mips_bus_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        DATA   = 3'd2,
        COMMIT = 3'd3,
        HALT   = 3'd4
    } bridge_state_t;

    localparam logic [3:0]  BYTEEN_WORD  = 4'hF;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

    // The bus is word addressed, so the low byte-offset bits are cleared.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/mips_harvard_bus_bridge_if.sv
// Avalon-style shared memory bus.
// The bridge connects through the master modport and the memory through the slave modport.
interface mips_harvard_bus_bridge_if;

    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_writedata;
    logic [3:0]  bus_byteenable;
    logic        bus_waitrequest;
    logic [31:0] bus_readdata;

    modport master (
        output bus_address,
        output bus_read,
        output bus_write,
        output bus_writedata,
        output bus_byteenable,
        input  bus_waitrequest,
        input  bus_readdata
    );

    modport slave (
        input  bus_address,
        input  bus_read,
        input  bus_write,
        input  bus_writedata,
        input  bus_byteenable,
        output bus_waitrequest,
        output bus_readdata
    );

endinterface

// File: rtl/mips_harvard_bus_bridge_bus_wait_timer.sv
// Counts stalled bus cycles within one transaction and flags when the limit is hit.
// The count saturates at the limit and never wraps.
module bus_wait_timer #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic inc_i,
    output logic limit_o
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(WAIT_LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < LIMIT_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Asserted in the stalled cycle that brings the count up to the limit.
    assign limit_o = (cnt_d == LIMIT_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_harvard_bus_bridge.sv
// Serialises the CPU's instruction and data ports onto one shared bus.
// Sequence: fetch, optional data access, then a one-cycle clock_enable commit.
module mips_harvard_bus_bridge
    import mips_bus_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_instr_address,
    output logic [31:0] cpu_instr_readdata,
    input  logic [31:0] cpu_data_address,
    input  logic        cpu_data_read,
    input  logic        cpu_data_write,
    input  logic [31:0] cpu_data_writedata,
    input  logic [3:0]  cpu_data_byteenable,
    output logic [31:0] cpu_data_readdata,
    input  logic        cpu_active,
    output logic        cpu_clock_enable,
    mips_harvard_bus_bridge_if.master bus,
    output logic        bus_error,
    output logic        halted
);

    bridge_state_t state_q, state_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          is_read_q, is_read_d;
    logic          err_q, err_d;

    logic          fetch_st;
    logic          data_st;
    logic          strobe;
    logic          wait_limit;

    assign fetch_st = (state_q == FETCH);
    assign data_st  = (state_q == DATA);
    assign strobe   = fetch_st || data_st;

    // Counter is cleared in the idle states, so every FETCH and DATA starts from zero.
    bus_wait_timer #(
        .WAIT_LIMIT(WAIT_LIMIT),
        .CNT_W     (CNT_W)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (reset),
        .clear_i((state_q == DECODE) || (state_q == COMMIT)),
        .inc_i  (strobe && bus.bus_waitrequest),
        .limit_o(wait_limit)
    );

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        rdata_d   = rdata_q;
        is_read_d = is_read_q;
        err_d     = err_q;
        unique case (state_q)
            FETCH: begin
                if (!bus.bus_waitrequest) begin
                    instr_d = bus.bus_readdata;
                    state_d = DECODE;
                end else if (wait_limit) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end
            end
            DECODE: begin
                // Read wins when both are requested (sub-word store read phase).
                is_read_d = cpu_data_read;
                state_d   = (cpu_data_read || cpu_data_write) ? DATA : COMMIT;
            end
            DATA: begin
                if (!bus.bus_waitrequest) begin
                    if (is_read_q) begin
                        rdata_d = bus.bus_readdata;
                    end
                    state_d = COMMIT;
                end else if (wait_limit) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end
            end
            COMMIT:  state_d = cpu_active ? FETCH : HALT;
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            instr_q   <= '0;
            rdata_q   <= '0;
            is_read_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            rdata_q   <= rdata_d;
            is_read_q <= is_read_d;
            err_q     <= err_d;
        end
    end

    // Strobes are gated by reset so they drop the instant reset asserts.
    assign bus.bus_read       = reset && (fetch_st || (data_st && is_read_q));
    assign bus.bus_write      = reset && data_st && !is_read_q;
    assign bus.bus_address    = word_align(data_st ? cpu_data_address : cpu_instr_address);
    assign bus.bus_writedata  = cpu_data_writedata;
    assign bus.bus_byteenable = (data_st && !is_read_q) ? cpu_data_byteenable : BYTEEN_WORD;

    assign cpu_instr_readdata = instr_q;
    assign cpu_data_readdata  = rdata_q;
    assign cpu_clock_enable   = (state_q == COMMIT);
    assign halted             = (state_q == HALT);
    assign bus_error          = err_q;

endmodule

// File: doc/mips_harvard_bus_bridge.md
Name: mips_harvard_bus_bridge

Overview:
- Sits directly between mips_cpu_harvard and a single shared Avalon-style memory bus.
- Serialises the CPU's separate instruction and data ports onto one bus: fetch, then optional data access, then a one-cycle CPU advance via clock_enable.
- Holds the fetched instruction stable in a register so the CPU's combinational decode and data requests stay valid across multi-cycle bus transactions.
- Adds a bus-wait timeout with a sticky error flag.

Parameters:
- WAIT_LIMIT, 16, max consecutive waitrequest-high cycles tolerated per transaction before bus_error.
- CNT_W, 5, width of the wait counter; must satisfy 2**CNT_W > WAIT_LIMIT.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- cpu_instr_address  input  32  CPU instruction address.
- cpu_instr_readdata  output  32  latched instruction word to CPU, raw bus byte order.
- cpu_data_address  input  32  CPU data address.
- cpu_data_read  input  1  CPU load request.
- cpu_data_write  input  1  CPU store request.
- cpu_data_writedata  input  32  CPU store data.
- cpu_data_byteenable  input  4  CPU store lane mask.
- cpu_data_readdata  output  32  latched load data to CPU.
- cpu_active  input  1  CPU active flag; 0 = halted.
- cpu_clock_enable  output  1  one-cycle pulse that commits one CPU instruction.
- bus_address  output  32  word address; [1:0] forced to 0.
- bus_read  output  1  bus read strobe.
- bus_write  output  1  bus write strobe.
- bus_writedata  output  32  store data.
- bus_byteenable  output  4  lane mask; 4'hF for reads and fetches.
- bus_waitrequest  input  1  slave stall; a transfer completes in a cycle where the strobe is high and waitrequest is low.
- bus_readdata  input  32  read data, valid in the completing cycle.
- bus_error  output  1  sticky timeout flag.
- halted  output  1  high in HALT.

Behaviour:
- States (mips_bus_pkg::bridge_state_t): FETCH, DECODE, DATA, COMMIT, HALT.
- Reset (reset=0, asynchronous):
  - State goes to FETCH.
  - All bus strobes, cpu_clock_enable, bus_error and halted are 0.
  - Instruction and data latches are 0; wait counter is 0.
- First bus_read is asserted in the first cycle after reset returns to 1.
- FETCH:
  - Drives bus_address={cpu_instr_address[31:2],2'b00}, bus_read=1, bus_byteenable=4'hF.
  - On !bus_waitrequest: latch bus_readdata into the instruction register and go to DECODE.
- DECODE:
  - No strobes. Gives the CPU one cycle to decode the latched instruction.
  - Samples cpu_data_read/cpu_data_write at the end of the cycle.
  - If either is high, go to DATA; else go to COMMIT.
  - If both are high, the read takes priority (this covers the CPU's SB/SH read-modify phase).
- DATA:
  - Drives bus_address={cpu_data_address[31:2],2'b00}.
  - Read: bus_read=1, bus_byteenable=4'hF.
  - Write: bus_write=1, bus_writedata=cpu_data_writedata, bus_byteenable=cpu_data_byteenable.
  - On completion, a read latches bus_readdata into cpu_data_readdata; then go to COMMIT.
- COMMIT:
  - cpu_clock_enable=1 for exactly one cycle.
  - Next state is HALT if cpu_active==0, else FETCH.
- HALT:
  - Absorbing until reset. No strobes, cpu_clock_enable=0, halted=1.
- Strobes are never asserted in two consecutive transactions without passing through DECODE or COMMIT.
- Bus outputs hold stable while waitrequest is high.
- Latency with zero-wait bus:
  - Non-memory instruction: 3 cycles (FETCH, DECODE, COMMIT).
  - Load or store: 4 cycles.
  - Each waitrequest cycle adds 1.
- Wait counter:
  - Cleared on entering FETCH or DATA.
  - Increments each cycle a strobe is high with waitrequest high.
  - When the counter reaches WAIT_LIMIT: bus_error<=1, strobes drop next cycle, state goes to HALT.
  - The counter saturates and never wraps.
- Latched instruction and data hold until the next successful transfer. cpu_instr_readdata is stable from DECODE through COMMIT.
- Reset asserted mid-transaction: strobes drop immediately (asynchronous), and the transaction is abandoned.

Decomposition:
- mips_bus_pkg holds:
  - bridge_state_t enum.
  - BYTEEN_WORD=4'hF constant.
  - RESET_VECTOR=32'hBFC00000 constant, for shared bench use.
- One sub-module: bus_wait_timer (CNT_W counter with clear, enable, saturate and limit-reached output), instantiated once.

Test Plan:
- Zero-wait fetch of 0x00000000 at 0xBFC00000:
  - bus_read is high in cycle 1 after reset release with bus_address=0xBFC00000.
  - cpu_clock_enable pulses in cycle 3; the next fetch starts in cycle 4.
- Load, data_address=0x00001006, readdata=0xDEADBEEF, waitrequest held high 2 cycles:
  - bus_address=0x00001004 and bus_read is held for 3 cycles.
  - cpu_data_readdata=0xDEADBEEF; cpu_clock_enable pulses 1 cycle after completion.
- Store, writedata=0x12345678, byteenable=4'b0011, zero wait:
  - bus_write is high for exactly 1 cycle with matching data and lanes.
  - Total instruction latency is 4 cycles.
- Timeout, WAIT_LIMIT=16, waitrequest stuck high during FETCH:
  - bus_error rises after 16 wait cycles; bus_read falls next cycle.
  - halted=1 and stays there; cpu_clock_enable is never pulsed.
- Reset driven to 0 during DATA with waitrequest high:
  - bus_write and bus_read go to 0 in the same cycle.
  - After reset returns to 1, a fresh FETCH starts.
- cpu_active=0 sampled in COMMIT:
  - HALT is entered and no further bus activity occurs over 50 cycles.
